// File: rtl/sevenseg_pattern_monitor_if.sv
// Bus bundle between a 7-segment pattern source and sevenseg_pattern_monitor.
// The optional digit_changes line exists only when SEVENSEG_MON_CHANGE_CNT_EN is defined.
interface sevenseg_pattern_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [6:0]       seg_in;
    logic             clr_err;
    logic [3:0]       bin_out;
    logic             digit_valid;
    logic             blank;
    logic             pattern_err;
    logic [CNT_W-1:0] err_count;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
    logic [CNT_W-1:0] digit_changes;
`endif

`ifdef SEVENSEG_MON_CHANGE_CNT_EN
    modport master (
        output en, seg_in, clr_err,
        input  bin_out, digit_valid, blank, pattern_err, err_count, digit_changes
    );

    modport slave (
        input  en, seg_in, clr_err,
        output bin_out, digit_valid, blank, pattern_err, err_count, digit_changes
    );
`else
    modport master (
        output en, seg_in, clr_err,
        input  bin_out, digit_valid, blank, pattern_err, err_count
    );

    modport slave (
        input  en, seg_in, clr_err,
        output bin_out, digit_valid, blank, pattern_err, err_count
    );
`endif
endinterface

// File: rtl/sevenseg_pattern_monitor.sv
// Recovers the hex nibble shown on an active-low 7-segment bus once the pattern is stable.
// Optional feature macro: SEVENSEG_MON_CHANGE_CNT_EN adds the digit_changes counter.
module sevenseg_pattern_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sevenseg_pattern_monitor_if.slave   mon
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    state_t           state, state_nxt;
    logic [6:0]       seg_q, seg_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [3:0]       bin_q, bin_nxt;
    logic             blank_q, blank_nxt;
    logic             dv_q, dv_nxt;
    logic             perr_q, perr_nxt;
    logic [CNT_W-1:0] err_q, err_nxt;

    logic             new_pat;
    logic             accept;
    logic             legal;
    logic             is_blank;
    logic [3:0]       glyph;

`ifdef SEVENSEG_MON_CHANGE_CNT_EN
    logic             has_digit_q, has_digit_nxt;
    logic [CNT_W-1:0] chg_q, chg_nxt;
`endif

    // Glyph table mirrors the HEX decoder; all-off is tracked separately from the digits.
    always_comb begin
        legal    = 1'b1;
        is_blank = 1'b0;
        glyph    = 4'h0;
        case (mon.seg_in)
            7'h40: glyph = 4'h0;
            7'h79: glyph = 4'h1;
            7'h24: glyph = 4'h2;
            7'h30: glyph = 4'h3;
            7'h19: glyph = 4'h4;
            7'h12: glyph = 4'h5;
            7'h02: glyph = 4'h6;
            7'h78: glyph = 4'h7;
            7'h00: glyph = 4'h8;
            7'h10: glyph = 4'h9;
            7'h08: glyph = 4'hA;
            7'h03: glyph = 4'hB;
            7'h46: glyph = 4'hC;
            7'h21: glyph = 4'hD;
            7'h06: glyph = 4'hE;
            7'h0E: glyph = 4'hF;
            7'h7F: begin
                legal    = 1'b0;
                is_blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // The incoming pattern is classified on the edge its run length reaches STABLE, so
    // with STABLE = 1 a fresh pattern is accepted on its capture edge.
    always_comb begin
        state_nxt = state;
        seg_nxt   = seg_q;
        cnt_nxt   = cnt;
        bin_nxt   = bin_q;
        blank_nxt = blank_q;
        dv_nxt    = 1'b0;
        perr_nxt  = 1'b0;
        err_nxt   = err_q;
        new_pat   = 1'b0;
        accept    = 1'b0;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
        has_digit_nxt = has_digit_q;
        chg_nxt       = chg_q;
`endif

        if (!mon.en) begin
            state_nxt = IDLE;
            seg_nxt   = 7'h7F;
            cnt_nxt   = 4'd0;
        end else begin
            new_pat = (state == IDLE) || (mon.seg_in != seg_q);
            seg_nxt = mon.seg_in;
            if (new_pat) begin
                cnt_nxt = 4'd1;
            end else if (cnt < STABLE) begin
                cnt_nxt = cnt + 4'd1;
            end

            accept = (cnt_nxt == STABLE) && (new_pat || state == TRACK);

            if (accept) begin
                state_nxt = LOCKED;
            end else if (new_pat) begin
                state_nxt = TRACK;
            end

            if (accept) begin
                if (legal) begin
                    bin_nxt   = glyph;
                    blank_nxt = 1'b0;
                    dv_nxt    = 1'b1;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
                    has_digit_nxt = 1'b1;
                    if (has_digit_q && (glyph != bin_q) && (chg_q != '1)) begin
                        chg_nxt = chg_q + 1'b1;
                    end
`endif
                end else if (is_blank) begin
                    blank_nxt = 1'b1;
                end else begin
                    perr_nxt = 1'b1;
                    if (err_q != '1) begin
                        err_nxt = err_q + 1'b1;
                    end
                end
            end
        end

        if (mon.clr_err) begin
            err_nxt = '0;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
            chg_nxt = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            seg_q   <= 7'h7F;
            cnt     <= 4'd0;
            bin_q   <= 4'h0;
            blank_q <= 1'b1;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            err_q   <= '0;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
            has_digit_q <= 1'b0;
            chg_q       <= '0;
`endif
        end else begin
            state   <= state_nxt;
            seg_q   <= seg_nxt;
            cnt     <= cnt_nxt;
            bin_q   <= bin_nxt;
            blank_q <= blank_nxt;
            dv_q    <= dv_nxt;
            perr_q  <= perr_nxt;
            err_q   <= err_nxt;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
            has_digit_q <= has_digit_nxt;
            chg_q       <= chg_nxt;
`endif
        end
    end

    assign mon.bin_out     = bin_q;
    assign mon.digit_valid = dv_q;
    assign mon.blank       = blank_q;
    assign mon.pattern_err = perr_q;
    assign mon.err_count   = err_q;
`ifdef SEVENSEG_MON_CHANGE_CNT_EN
    assign mon.digit_changes = chg_q;
`endif

endmodule

// File: tb/tb_sevenseg_pattern_monitor.sv
// Directed bench for sevenseg_pattern_monitor with STABLE_CYCLES = 4 and CNT_W = 8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sevenseg_pattern_monitor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sevenseg_pattern_monitor_if #(.CNT_W(8)) mon_if ();

    sevenseg_pattern_monitor #(
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (mon_if.slave)
    );

    int checks   = 0;
    int passes   = 0;
    int dv_cnt   = 0;
    int pe_cnt   = 0;
    int both_cnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Holds the given inputs for a number of clock cycles while tallying output pulses.
    task automatic applyStimulus(input logic [6:0] seg, input logic en, input logic clr,
                                 input int cycles);
        mon_if.seg_in  = seg;
        mon_if.en      = en;
        mon_if.clr_err = clr;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            if (mon_if.digit_valid) dv_cnt++;
            if (mon_if.pattern_err) pe_cnt++;
            if (mon_if.digit_valid && mon_if.pattern_err) both_cnt++;
        end
    endtask

    initial begin
        logic [6:0] toggle_seg;

        rst_n          = 1'b0;
        mon_if.en      = 1'b0;
        mon_if.seg_in  = 7'h7F;
        mon_if.clr_err = 1'b0;
        applyStimulus(7'h7F, 1'b0, 1'b0, 2);
        checkOutput("rst_bin", 32'(mon_if.bin_out), 32'h0);
        checkOutput("rst_dv", 32'(mon_if.digit_valid), 32'h0);
        checkOutput("rst_blank", 32'(mon_if.blank), 32'h1);
        checkOutput("rst_perr", 32'(mon_if.pattern_err), 32'h0);
        checkOutput("rst_err", 32'(mon_if.err_count), 32'h0);
        rst_n = 1'b1;

        $display("[TB] stable digit 3");
        dv_cnt = 0;
        applyStimulus(7'h30, 1'b1, 1'b0, 3);
        checkOutput("t1_no_early_pulse", 32'(dv_cnt), 32'h0);
        applyStimulus(7'h30, 1'b1, 1'b0, 1);
        checkOutput("t1_pulse_at_4", 32'(mon_if.digit_valid), 32'h1);
        applyStimulus(7'h30, 1'b1, 1'b0, 4);
        checkOutput("t1_single_pulse", 32'(dv_cnt), 32'h1);
        checkOutput("t1_bin", 32'(mon_if.bin_out), 32'h3);
        checkOutput("t1_blank", 32'(mon_if.blank), 32'h0);
        checkOutput("t1_err", 32'(mon_if.err_count), 32'h0);

        $display("[TB] glitch filtering");
        dv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            toggle_seg = (i % 2 == 0) ? 7'h12 : 7'h02;
            applyStimulus(toggle_seg, 1'b1, 1'b0, 2);
        end
        checkOutput("t2_no_pulse_toggle", 32'(dv_cnt), 32'h0);
        applyStimulus(7'h02, 1'b1, 1'b0, 6);
        checkOutput("t2_one_pulse", 32'(dv_cnt), 32'h1);
        checkOutput("t2_bin", 32'(mon_if.bin_out), 32'h6);

        $display("[TB] blank then F");
        dv_cnt = 0;
        applyStimulus(7'h7F, 1'b1, 1'b0, 6);
        checkOutput("t3_blank_set", 32'(mon_if.blank), 32'h1);
        checkOutput("t3_blank_no_dv", 32'(dv_cnt), 32'h0);
        checkOutput("t3_blank_bin_hold", 32'(mon_if.bin_out), 32'h6);
        applyStimulus(7'h0E, 1'b1, 1'b0, 6);
        checkOutput("t3_f_dv", 32'(dv_cnt), 32'h1);
        checkOutput("t3_f_bin", 32'(mon_if.bin_out), 32'hF);
        checkOutput("t3_f_blank", 32'(mon_if.blank), 32'h0);

        $display("[TB] illegal patterns");
        dv_cnt = 0;
        pe_cnt = 0;
        applyStimulus(7'h55, 1'b1, 1'b0, 6);
        checkOutput("t4_perr_once", 32'(pe_cnt), 32'h1);
        checkOutput("t4_err_cnt", 32'(mon_if.err_count), 32'h1);
        checkOutput("t4_bin_hold", 32'(mon_if.bin_out), 32'hF);
        checkOutput("t4_blank_hold", 32'(mon_if.blank), 32'h0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(7'h7F, 1'b1, 1'b0, 4);
            applyStimulus(7'h55, 1'b1, 1'b0, 4);
        end
        checkOutput("t4_perr_total", 32'(pe_cnt), 32'd301);
        checkOutput("t4_err_saturate", 32'(mon_if.err_count), 32'd255);
        checkOutput("t4_no_dv", 32'(dv_cnt), 32'h0);
        applyStimulus(7'h7F, 1'b1, 1'b0, 4);
        applyStimulus(7'h55, 1'b1, 1'b0, 3);
        applyStimulus(7'h55, 1'b1, 1'b1, 1);
        checkOutput("t4_clr_perr", 32'(mon_if.pattern_err), 32'h1);
        checkOutput("t4_clr_wins", 32'(mon_if.err_count), 32'h0);
        applyStimulus(7'h55, 1'b1, 1'b0, 2);
        checkOutput("t4_clr_stays", 32'(mon_if.err_count), 32'h0);
        checkOutput("t4_no_repeat_perr", 32'(mon_if.pattern_err), 32'h0);

        $display("[TB] reset and disable mid-track");
        dv_cnt = 0;
        pe_cnt = 0;
        applyStimulus(7'h24, 1'b1, 1'b0, 3);
        rst_n = 1'b0;
        applyStimulus(7'h24, 1'b1, 1'b0, 1);
        checkOutput("t5_rst_bin", 32'(mon_if.bin_out), 32'h0);
        checkOutput("t5_rst_blank", 32'(mon_if.blank), 32'h1);
        checkOutput("t5_rst_err", 32'(mon_if.err_count), 32'h0);
        checkOutput("t5_rst_no_dv", 32'(dv_cnt), 32'h0);
        checkOutput("t5_rst_no_perr", 32'(pe_cnt), 32'h0);
        rst_n = 1'b1;
        applyStimulus(7'h12, 1'b1, 1'b0, 4);
        checkOutput("t5_digit5_dv", 32'(mon_if.digit_valid), 32'h1);
        checkOutput("t5_digit5_bin", 32'(mon_if.bin_out), 32'h5);
        dv_cnt = 0;
        applyStimulus(7'h24, 1'b1, 1'b0, 2);
        applyStimulus(7'h24, 1'b0, 1'b0, 3);
        checkOutput("t5_dis_no_dv", 32'(dv_cnt), 32'h0);
        checkOutput("t5_dis_bin_hold", 32'(mon_if.bin_out), 32'h5);
        applyStimulus(7'h24, 1'b1, 1'b0, 3);
        checkOutput("t5_reen_no_early", 32'(dv_cnt), 32'h0);
        applyStimulus(7'h24, 1'b1, 1'b0, 1);
        checkOutput("t5_reen_dv", 32'(mon_if.digit_valid), 32'h1);
        checkOutput("t5_reen_bin", 32'(mon_if.bin_out), 32'h2);
        checkOutput("t5_never_both", 32'(both_cnt), 32'h0);

`ifdef SEVENSEG_MON_CHANGE_CNT_EN
        $display("[TB] digit change counter");
        rst_n = 1'b0;
        applyStimulus(7'h7F, 1'b0, 1'b0, 1);
        rst_n = 1'b1;
        dv_cnt = 0;
        applyStimulus(7'h12, 1'b1, 1'b0, 5);
        checkOutput("t6_first_no_inc", 32'(mon_if.digit_changes), 32'h0);
        applyStimulus(7'h7F, 1'b1, 1'b0, 5);
        applyStimulus(7'h12, 1'b1, 1'b0, 5);
        checkOutput("t6_same_no_inc", 32'(mon_if.digit_changes), 32'h0);
        applyStimulus(7'h10, 1'b1, 1'b0, 5);
        checkOutput("t6_dv_count", 32'(dv_cnt), 32'd3);
        checkOutput("t6_bin", 32'(mon_if.bin_out), 32'h9);
        checkOutput("t6_changes", 32'(mon_if.digit_changes), 32'h1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
